// File: rtl/tcp_vlg_tx_arb_if.sv
// Requester-side and IPv4-side signals of tcp_vlg_tx_arb.
// The arbiter takes the master view; the controllers and IPv4 TX take the slave view.
interface tcp_vlg_tx_arb_if #(
    parameter int N = 4
);
    localparam int SW = $clog2(N);

    logic [N-1:0]    req;
    logic [N*16-1:0] len;
    logic [N-1:0]    send;
    logic [N-1:0]    sent;
    logic [N-1:0]    src_val;
    logic [N-1:0]    src_sof;
    logic [N-1:0]    src_eof;
    logic [N*8-1:0]  src_dat;
    logic            out_req;
    logic            out_ack;
    logic [15:0]     out_len;
    logic [SW-1:0]   out_src;
    logic            out_val;
    logic            out_sof;
    logic            out_eof;
    logic [7:0]      out_dat;
    logic            out_abort;
    logic            len_err;

    modport master (
        input  req, len, src_val, src_sof, src_eof, src_dat, out_ack,
        output send, sent, out_req, out_len, out_src,
               out_val, out_sof, out_eof, out_dat, out_abort, len_err
    );

    modport slave (
        output req, len, src_val, src_sof, src_eof, src_dat, out_ack,
        input  send, sent, out_req, out_len, out_src,
               out_val, out_sof, out_eof, out_dat, out_abort, len_err
    );
endinterface

// File: rtl/tcp_vlg_tx_arb.sv
// Round-robin arbiter sharing one IPv4 TX path among N TCP TX controllers: grant,
// start pulse, one-cycle stream forwarding, length check, timeout abort, inter-packet gap.
module tcp_vlg_tx_arb #(
    parameter int N             = 4,
    parameter int IFG_TICKS     = 12,
    parameter int TIMEOUT_TICKS = 1000
) (
    input  logic             clk,
    input  logic             rst,
    tcp_vlg_tx_arb_if.master bus,
    output logic             busy
);
    localparam int SW       = $clog2(N);
    localparam int IW       = $clog2(TIMEOUT_TICKS + 1);
    localparam int GAP_LAST = (IFG_TICKS > 0) ? IFG_TICKS - 1 : 0;
    localparam int GW       = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, STRM, GAP} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [SW-1:0] last;
    logic [SW-1:0] src_q;
    logic [15:0]   len_q;
    logic [15:0]   byte_cnt;
    logic [IW-1:0] idle_cnt;
    logic [GW-1:0] gap_cnt;

    logic [N-1:0]  send_q;
    logic [N-1:0]  sent_q;
    logic          val_q;
    logic          sof_q;
    logic          eof_q;
    logic [7:0]    dat_q;
    logic          abort_q;
    logic          len_err_q;

    logic          pick_vld;
    logic [SW-1:0] pick_idx;
    logic [SW-1:0] cand;
    logic [15:0]   pick_len;

    logic          sel_req;
    logic          sel_val;
    logic          sel_sof;
    logic          sel_eof;
    logic [7:0]    sel_dat;
    logic [N-1:0]  src_onehot;

    logic          grant;
    logic          start;
    logic          fin_eof;
    logic          fin_abort;
    logic          idle_hit;
    logic          gap_done;

    // Scan last+1, last+2, ... so the most recently served requester is checked last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SW'((int'(last) + k) % N);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign pick_len   = bus.len[{pick_idx, 4'b0000} +: 16];

    assign sel_req    = bus.req[src_q];
    assign sel_val    = bus.src_val[src_q];
    assign sel_sof    = bus.src_sof[src_q];
    assign sel_eof    = bus.src_eof[src_q];
    assign sel_dat    = bus.src_dat[{src_q, 3'b000} +: 8];
    assign src_onehot = N'(1) << src_q;

    // The idle count seen in a cycle equals the cycles elapsed since send, so the abort
    // registered on the edge where it would reach TIMEOUT_TICKS lands exactly that far out.
    assign idle_hit = !sel_val && (idle_cnt == IW'(TIMEOUT_TICKS - 1));
    assign gap_done = (gap_cnt == GW'(GAP_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        start     = 1'b0;
        fin_eof   = 1'b0;
        fin_abort = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.out_ack) begin
                    start     = 1'b1;
                    state_nxt = STRM;
                end else if (!sel_req) begin
                    state_nxt = IDLE;
                end
            end
            STRM: begin
                if (sel_val && sel_eof) begin
                    fin_eof   = 1'b1;
                    state_nxt = GAP;
                end else if (idle_hit) begin
                    fin_abort = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= SW'(N - 1);
            src_q     <= '0;
            len_q     <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            gap_cnt   <= '0;
            send_q    <= '0;
            sent_q    <= '0;
            val_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            dat_q     <= '0;
            abort_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            send_q    <= '0;
            sent_q    <= '0;
            abort_q   <= 1'b0;
            len_err_q <= 1'b0;
            val_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            dat_q     <= '0;

            if (grant) begin
                src_q <= pick_idx;
                len_q <= pick_len;
                last  <= pick_idx;
            end

            if (start) begin
                send_q   <= src_onehot;
                byte_cnt <= '0;
                idle_cnt <= '0;
            end

            if (state == STRM) begin
                if (!fin_abort) begin
                    val_q <= sel_val;
                    sof_q <= sel_sof;
                    eof_q <= sel_eof;
                    dat_q <= sel_dat;
                end
                if (sel_val) begin
                    byte_cnt <= (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            if (fin_eof) begin
                sent_q    <= src_onehot;
                len_err_q <= (({1'b0, byte_cnt} + 17'd1) != {1'b0, len_q});
            end

            if (fin_abort) begin
                sent_q  <= src_onehot;
                abort_q <= 1'b1;
            end

            // The eof/abort cycle is the first of the gap cycles.
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    assign bus.out_req   = (state == REQ);
    assign bus.out_src   = src_q;
    assign bus.out_len   = len_q;
    assign bus.send      = send_q;
    assign bus.sent      = sent_q;
    assign bus.out_val   = val_q;
    assign bus.out_sof   = sof_q;
    assign bus.out_eof   = eof_q;
    assign bus.out_dat   = dat_q;
    assign bus.out_abort = abort_q;
    assign bus.len_err   = len_err_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// Randomized bench for tcp_vlg_tx_arb; expectations come from a transaction-level model
// (round-robin pick over a request mask, byte queues, cycle distances).
`timescale 1ns/1ps
module tb_tcp_vlg_tx_arb;
    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    int total = 0;
    int bad   = 0;

    int         m_last;
    int         m_len[N];
    int         req_mask;
    logic [7:0] pkt[$];

    tcp_vlg_tx_arb_if #(.N(N)) bus ();

    tcp_vlg_tx_arb #(.N(N), .IFG_TICKS(IFG), .TIMEOUT_TICKS(TMO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int last, input int mask);
        for (int k = 1; k <= N; k++)
            if (((mask >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Selected source gets the given beat; every other source carries noise.
    task automatic drive(input int sel, input logic v, input logic s, input logic e, input logic [7:0] d);
        logic [N-1:0]   keep;
        logic [N*8-1:0] keep_d;
        bus.src_val = N'($urandom);
        bus.src_sof = N'($urandom);
        bus.src_eof = N'($urandom);
        bus.src_dat = (N*8)'($urandom);
        if (sel >= 0) begin
            keep        = ~(N'(1) << sel);
            keep_d      = ~((N*8)'(8'hFF) << (8 * sel));
            bus.src_val = (bus.src_val & keep) | (N'(v) << sel);
            bus.src_sof = (bus.src_sof & keep) | (N'(s) << sel);
            bus.src_eof = (bus.src_eof & keep) | (N'(e) << sel);
            bus.src_dat = (bus.src_dat & keep_d) | ((N*8)'(d) << (8 * sel));
        end
    endtask

    task automatic set_len(input int i, input int l);
        m_len[i] = l;
        bus.len  = (bus.len & ~((N*16)'(16'hFFFF) << (16 * i))) | ((N*16)'(l[15:0]) << (16 * i));
    endtask

    task automatic set_req(input int mask);
        req_mask = mask;
        bus.req  = N'(mask);
    endtask

    task automatic grant_phase(input int ack_dly, output int idx, output bit ok);
        logic [N-1:0] oh;
        int n;
        idx    = rr_pick(m_last, req_mask);
        m_last = idx;
        oh     = N'(1) << idx;
        n      = 0;
        while (bus.out_req !== 1'b1 && n < 20) begin
            drive(-1, 1'b0, 1'b0, 1'b0, 8'h00);
            tick();
            n++;
        end
        ok = (bus.out_req === 1'b1);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL grant_wait: out_req=%b after %0d cycles, want 1", bus.out_req, n);
            return;
        end
        total++;
        if (bus.out_src !== idx) begin
            bad++; $display("FAIL grant_src: out_src=%0d want %0d", bus.out_src, idx);
        end
        total++;
        if (bus.out_len !== 16'(m_len[idx])) begin
            bad++; $display("FAIL grant_len: out_len=%0d want %0d", bus.out_len, m_len[idx]);
        end
        total++;
        if (busy !== 1'b1 || bus.send !== '0) begin
            bad++; $display("FAIL req_state: busy=%b send=%b want busy=1 send=0", busy, bus.send);
        end
        for (int d = 0; d < ack_dly; d++) begin
            tick();
            total++;
            if (bus.out_req !== 1'b1 || bus.send !== '0) begin
                bad++; $display("FAIL req_hold: out_req=%b send=%b want 1/0", bus.out_req, bus.send);
            end
        end
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        total++;
        if (bus.out_req !== 1'b0 || bus.send !== oh) begin
            bad++; $display("FAIL send_pulse: out_req=%b send=%b want 0/%b", bus.out_req, bus.send, oh);
        end
    endtask

    task automatic gap_phase();
        drive(-1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int g = 1; g < ((IFG > 0) ? IFG : 1); g++) begin
            tick();
            total++;
            if (busy !== 1'b1 || bus.out_val !== 1'b0 || bus.out_eof !== 1'b0 ||
                bus.sent !== '0 || bus.out_req !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold: cycle %0d busy=%b val=%b eof=%b sent=%b req=%b want 1/0/0/0/0",
                         g, busy, bus.out_val, bus.out_eof, bus.sent, bus.out_req);
            end
            drive(-1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        tick();
        total++;
        if (busy !== 1'b0 || bus.out_req !== 1'b0) begin
            bad++; $display("FAIL gap_end: busy=%b out_req=%b want 0/0", busy, bus.out_req);
        end
    endtask

    task automatic stream_phase(input int idx, input int nbytes, input int gap_max);
        logic [N-1:0] oh;
        logic [7:0]   d;
        logic         exp_err;
        oh      = N'(1) << idx;
        exp_err = (nbytes != m_len[idx]);
        for (int b = 0; b < nbytes; b++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int j = 0; j < g; j++) begin
                d = 8'($urandom);
                drive(idx, 1'b0, 1'b0, 1'b0, d);
                tick();
                total++;
                if ({bus.out_val, bus.out_sof, bus.out_eof} !== 3'b000 || bus.out_dat !== d || bus.sent !== '0) begin
                    bad++;
                    $display("FAIL fwd_idle: val/sof/eof=%b%b%b dat=%h sent=%b want 000 %h 0",
                             bus.out_val, bus.out_sof, bus.out_eof, bus.out_dat, bus.sent, d);
                end
            end
            d = (pkt.size() > 0) ? pkt.pop_front() : 8'($urandom);
            drive(idx, 1'b1, b == 0, b == nbytes - 1, d);
            tick();
            total++;
            if (bus.out_val !== 1'b1 || bus.out_dat !== d || bus.out_sof !== (b == 0) ||
                bus.out_eof !== (b == nbytes - 1)) begin
                bad++;
                $display("FAIL fwd_byte: byte %0d val=%b dat=%h sof=%b eof=%b want 1 %h %b %b",
                         b, bus.out_val, bus.out_dat, bus.out_sof, bus.out_eof, d, b == 0, b == nbytes - 1);
            end
            total++;
            if (b == nbytes - 1) begin
                if (bus.sent !== oh || bus.len_err !== exp_err || bus.out_abort !== 1'b0) begin
                    bad++;
                    $display("FAIL eof_status: sent=%b len_err=%b abort=%b want %b %b 0",
                             bus.sent, bus.len_err, bus.out_abort, oh, exp_err);
                end
            end else if (bus.sent !== '0 || bus.len_err !== 1'b0) begin
                bad++; $display("FAIL mid_status: sent=%b len_err=%b want 0/0", bus.sent, bus.len_err);
            end
        end
        gap_phase();
    endtask

    task automatic run_packet(input int nb_delta, input int ack_dly, input int gap_max);
        int idx;
        int nb;
        bit ok;
        grant_phase(ack_dly, idx, ok);
        if (ok) begin
            nb = m_len[idx] + nb_delta;
            if (nb < 1) nb = 1;
            stream_phase(idx, nb, gap_max);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.send, bus.sent, bus.out_req, bus.out_len, bus.out_src, bus.out_val, bus.out_sof,
             bus.out_eof, bus.out_dat, bus.out_abort, bus.len_err, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: send=%b sent=%b req=%b len=%0d src=%0d val=%b busy=%b want all 0",
                     bus.send, bus.sent, bus.out_req, bus.out_len, bus.out_src, bus.out_val, busy);
        end
        rst    = 1'b0;
        m_last = N - 1;
    endtask

    task automatic test_fairness();
        set_req('b1011);
        for (int i = 0; i < N; i++) set_len(i, 1);
        for (int p = 0; p < 6; p++) run_packet(0, 0, 0);
    endtask

    task automatic test_basic();
        set_req('b0001);
        set_len(0, 3);
        pkt.push_back(8'hA1);
        pkt.push_back(8'hB2);
        pkt.push_back(8'hC3);
        run_packet(0, 1, 0);
    endtask

    task automatic test_len_err();
        set_req('b0100);
        set_len(2, 5);
        run_packet(-1, 0, 1);
    endtask

    task automatic test_withdraw();
        int idx;
        int n;
        set_req('b1000);
        set_len(0, 2);
        idx = rr_pick(m_last, req_mask);
        n   = 0;
        while (bus.out_req !== 1'b1 && n < 20) begin
            drive(-1, 1'b0, 1'b0, 1'b0, 8'h00);
            tick();
            n++;
        end
        total++;
        if (bus.out_req !== 1'b1 || bus.out_src !== idx) begin
            bad++; $display("FAIL withdraw_grant: out_req=%b out_src=%0d want 1/%0d", bus.out_req, bus.out_src, idx);
        end
        m_last = idx;
        set_req('b0101);
        tick();
        total++;
        if (bus.out_req !== 1'b0 || bus.send !== '0 || bus.sent !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL withdraw: out_req=%b send=%b sent=%b busy=%b want 0/0/0/0",
                     bus.out_req, bus.send, bus.sent, busy);
        end
        run_packet(0, 0, 0);
    endtask

    task automatic test_timeout();
        int idx;
        int n;
        bit ok;
        bit seen;
        bit early;
        set_req('b0010);
        set_len(1, 10);
        grant_phase(0, idx, ok);
        if (!ok) return;
        n     = 0;
        seen  = 1'b0;
        early = 1'b0;
        while (n < TMO + 50 && !seen) begin
            drive(idx, 1'b0, 1'b0, 1'b0, 8'($urandom));
            tick();
            n++;
            if (bus.out_abort === 1'b1) seen = 1'b1;
            else if (bus.sent !== '0 || bus.out_val !== 1'b0) early = 1'b1;
        end
        total++;
        if (!seen || n != TMO || early) begin
            bad++; $display("FAIL abort_time: abort seen=%b after %0d cycles early=%b, want 1 after %0d early=0",
                            seen, n, early, TMO);
        end
        total++;
        if (bus.sent !== 4'b0010 || bus.out_val !== 1'b0 || bus.len_err !== 1'b0) begin
            bad++; $display("FAIL abort_status: sent=%b val=%b len_err=%b want 0010/0/0",
                            bus.sent, bus.out_val, bus.len_err);
        end
        set_req('b0000);
        gap_phase();
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int delta;
            set_req(int'($urandom_range((1 << N) - 1, 1)));
            for (int i = 0; i < N; i++) set_len(i, int'($urandom_range(8, 1)));
            delta = 0;
            if ($urandom_range(3, 0) == 0) delta = ($urandom_range(1, 0) == 1) ? 1 : -1;
            run_packet(delta, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
        end
    endtask

    task automatic test_reset_mid();
        int  idx;
        bit  ok;
        bit  fwd_bad;
        bit  leak;
        logic [7:0] d;
        set_req('b0001);
        set_len(0, 100);
        grant_phase(0, idx, ok);
        if (!ok) return;
        fwd_bad = 1'b0;
        for (int b = 0; b < 50; b++) begin
            d = 8'($urandom);
            drive(idx, 1'b1, b == 0, 1'b0, d);
            tick();
            if (bus.out_val !== 1'b1 || bus.out_dat !== d) fwd_bad = 1'b1;
        end
        total++;
        if (fwd_bad) begin
            bad++; $display("FAIL long_fwd: forwarded stream differs from source, want identical");
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.send, bus.sent, bus.out_req, bus.out_len, bus.out_src, bus.out_val, bus.out_sof,
             bus.out_eof, bus.out_dat, bus.out_abort, bus.len_err, busy} !== '0) begin
            bad++;
            $display("FAIL reset_mid: val=%b dat=%h len=%0d src=%0d busy=%b want all 0",
                     bus.out_val, bus.out_dat, bus.out_len, bus.out_src, busy);
        end
        leak = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.sent !== '0 || busy !== 1'b0) leak = 1'b1;
        end
        total++;
        if (leak) begin
            bad++; $display("FAIL reset_sent: sent or busy rose while in reset, want 0");
        end
        rst    = 1'b0;
        m_last = N - 1;
        set_len(0, 3);
        run_packet(0, 1, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.len     = '0;
        bus.out_ack = 1'b0;
        req_mask    = 0;
        drive(-1, 1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_fairness();
        test_basic();
        test_len_err();
        test_withdraw();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tcp_vlg_tx_arb.md
Name: tcp_vlg_tx_arb

Overview:
Round-robin scheduler that shares the single IPv4 transmit path between N TCP transmit controllers (one per connection).
- Grants one pending payload at a time.
- Issues the start pulse to the winning controller and forwards its byte stream to the IPv4 layer with one-cycle latency.
- Checks the byte count against the advertised length, and releases the path after an inter-packet gap.
- Sits between the per-connection TX controllers and the IPv4 TX block.

Parameters:
N, 4, number of requesting TCP TX controllers (2..16)
IFG_TICKS, 12, idle cycles forced between consecutive grants
TIMEOUT_TICKS, 1000, max cycles without source valid during streaming before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  N  requester i has a packet pending (level, held until sent/withdrawn)
len  in  N*16  payload length of requester i, slice [16*i+:16], valid while req[i]
send  out  N  one-cycle pulse: requester i start streaming
sent  out  N  one-cycle pulse: requester i packet completed or aborted
src_val  in  N  per-requester stream valid
src_sof  in  N  per-requester start of frame
src_eof  in  N  per-requester end of frame
src_dat  in  N*8  per-requester data, slice [8*i+:8]
out_req  out  1  request to IPv4 TX
out_ack  in  1  IPv4 TX accepted request, header phase started
out_len  out  16  latched length of granted packet
out_src  out  $clog2(N)  index of granted requester
out_val  out  1  forwarded valid
out_sof  out  1  forwarded sof
out_eof  out  1  forwarded eof
out_dat  out  8  forwarded data
out_abort  out  1  one-cycle pulse: current packet aborted (timeout)
len_err  out  1  one-cycle pulse with final out_eof when byte count != out_len
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, rr pointer last=N-1. All outputs 0: send, sent, out_req, out_len, out_src, out_val/sof/eof/dat, out_abort, len_err, busy.
- FSM states: IDLE, REQ, STRM, GAP.
- IDLE:
  - If |req, select the first set index scanning last+1, last+2, … mod N.
  - Latch out_src and out_len; set last=index. Next cycle: REQ, out_req=1.
- REQ:
  - out_req held high.
  - If out_ack: out_req=0, send[out_src]=1 for exactly one cycle, go STRM; byte counter=0, idle counter=0.
  - If req[out_src] deasserts before out_ack (withdrawal): out_req=0, go IDLE. No send/sent pulse. last keeps the withdrawn index.
  - If out_ack and withdrawal occur in the same cycle, out_ack wins.
- STRM:
  - out_val/sof/eof/dat are registered copies of src_* at out_src (1-cycle latency). Non-selected sources are ignored.
  - Byte counter (16-bit, saturating at 0xFFFF) increments on each selected src_val.
  - Idle counter resets on src_val, else increments.
  - On selected src_val&src_eof: the forwarded eof is emitted the next cycle, sent[out_src] pulses in that same cycle, and len_err=1 in that cycle if count+1 != out_len. Go GAP.
  - If idle counter reaches TIMEOUT_TICKS: out_abort=1 and sent[out_src]=1 for one cycle, out_val=0, go GAP.
  - src_sof mid-packet is forwarded unchanged; no check.
- GAP: IFG_TICKS cycles with all out_* stream signals 0, then IDLE. IFG_TICKS=0 gives one cycle in GAP.
- Fairness: a requester reasserting immediately after service is granted again only if no other req is set at the time of the IDLE scan.
- busy=1 in REQ, STRM, GAP.
- Reset mid-packet aborts silently: no sent pulse; outputs return to 0 immediately.

Test Plan:
- N=4, req=4'b0001, len[0]=3, out_ack after 2 cycles, source sends 3 bytes A1,B2,C3 sof/eof framed -> out_req high 2 cycles, send=0001 one cycle, out_dat A1,B2,C3 each one cycle after source, sent=0001 with out_eof, len_err=0, busy low after 12 GAP cycles.
- req=4'b1011 held, immediate acks, 1-byte packets -> grant order 0,1,3,0,1,3; out_src matches each grant.
- len[2]=5, source 2 sends 4 bytes then eof -> len_err=1 coincident with out_eof; sent[2]=1.
- Granted source 1 never asserts src_val after send -> out_abort=1 and sent=0010 exactly 1000 cycles after send; FSM returns to IDLE after gap.
- req[3] drops while in REQ with no out_ack -> out_req falls next cycle, no send pulse, next scan starts at index 0.
- Assert rst during STRM of a 100-byte packet -> all outputs 0 immediately, no sent pulse; after release, pending req=0001 is granted again from IDLE.
